// File: rtl/stmn_frame_assembler_pkg.sv
// Shared constants and types for the STM-N frame assembler: frame geometry,
// fixed overhead byte values, the J0 section trace and the frame position type.
package stmn_frame_assembler_pkg;

    localparam int STM1_LENGTH = 270;
    localparam int STM1_WIDTH  = 9;
    localparam int SOH_COLS    = 9;

    localparam int TRACE_MAX = 16;
    localparam int POS_COL_W = 13;  // wide enough for 270*16 columns

    localparam logic [7:0] A1_BYTE = 8'hF6;
    localparam logic [7:0] A2_BYTE = 8'h28;
    localparam logic [7:0] Z0_BYTE = 8'hCC;
    localparam logic [7:0] CI_H1   = 8'h9B;
    localparam logic [7:0] CI_H2   = 8'hFF;

    // "PARAM N " stored twice so any trace index up to TRACE_MAX-1 is valid.
    localparam logic [0:TRACE_MAX-1][7:0] J0_TRACE = {
        8'h50, 8'h41, 8'h52, 8'h41, 8'h4D, 8'h20, 8'h4E, 8'h20,
        8'h50, 8'h41, 8'h52, 8'h41, 8'h4D, 8'h20, 8'h4E, 8'h20
    };

    typedef struct packed {
        logic [3:0]           row;
        logic [POS_COL_W-1:0] col;
    } stm_pos_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_t;

    // H1 carries the new-data-flag pattern, the SS bits and the pointer MSBs.
    function automatic logic [7:0] h1_byte(input logic [9:0] ptr);
        return {4'b0110, 2'b10, ptr[9:8]};
    endfunction

endpackage

// File: rtl/stmn_frame_assembler_oh_gen.sv
// Combinational overhead generator: maps a frame position and J0 trace index
// to the section/pointer overhead byte and flags whether the column is overhead.
module stmn_oh_gen
    import stmn_frame_assembler_pkg::*;
#(
    parameter int STM_N     = 1,
    parameter int PTR_VALUE = 0
) (
    input  stm_pos_t   i_pos,
    input  logic [3:0] i_j0_idx,
    output logic [7:0] o_byte,
    output logic       o_is_overhead
);

    localparam logic [9:0] PTR_BITS = 10'(PTR_VALUE);
    localparam logic [7:0] H1_VAL   = h1_byte(PTR_BITS);
    localparam logic [7:0] H2_VAL   = PTR_BITS[7:0];

    localparam logic [POS_COL_W-1:0] C_N  = POS_COL_W'(STM_N);
    localparam logic [POS_COL_W-1:0] C_3N = POS_COL_W'(3 * STM_N);
    localparam logic [POS_COL_W-1:0] C_4N = POS_COL_W'(4 * STM_N);
    localparam logic [POS_COL_W-1:0] C_6N = POS_COL_W'(6 * STM_N);
    localparam logic [POS_COL_W-1:0] C_7N = POS_COL_W'(7 * STM_N);
    localparam logic [POS_COL_W-1:0] C_9N = POS_COL_W'(SOH_COLS * STM_N);

    logic [7:0] w_byte;

    always_comb begin
        w_byte = 8'h00;
        if (i_pos.row == 4'd0) begin
            if (i_pos.col < C_3N) begin
                w_byte = A1_BYTE;
            end else if (i_pos.col < C_6N) begin
                w_byte = A2_BYTE;
            end else if (i_pos.col == C_6N) begin
                w_byte = J0_TRACE[i_j0_idx];
            end else if (i_pos.col < C_7N) begin
                w_byte = Z0_BYTE;
            end
        end else if (i_pos.row == 4'd3) begin
            // AU-4 pointer row; H3 columns fall through to zero.
            if (i_pos.col < C_N) begin
                w_byte = H1_VAL;
            end else if (i_pos.col < C_3N) begin
                w_byte = CI_H1;
            end else if (i_pos.col < C_4N) begin
                w_byte = H2_VAL;
            end else if (i_pos.col < C_6N) begin
                w_byte = CI_H2;
            end
        end
    end

    assign o_byte        = w_byte;
    assign o_is_overhead = (i_pos.col < C_9N);

endmodule

// File: rtl/stmn_frame_assembler.sv
// Byte-serial STM-N frame assembler: walks row/col over a 9 x 270N frame,
// emitting generated overhead or upstream VC-4 payload through one output register.
module stmn_frame_assembler
    import stmn_frame_assembler_pkg::*;
#(
    parameter int STM_N     = 1,
    parameter int PTR_VALUE = 0,
    parameter int TRACE_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic [15:0] frame_cnt
);

    localparam int COLS  = STM1_LENGTH * STM_N;
    localparam int COL_W = $clog2(COLS);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [3:0]       LAST_ROW = 4'(STM1_WIDTH - 1);
    localparam logic [3:0]       LAST_J0  = 4'(TRACE_LEN - 1);

    fsm_state_t       r_state;
    logic [3:0]       r_row;
    logic [COL_W-1:0] r_col;
    logic [3:0]       r_j0_idx;
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_sof;
    logic [15:0]      r_frame_cnt;

    stm_pos_t   w_pos;
    logic [7:0] w_oh_byte;
    logic       w_is_oh;
    logic       w_run;
    logic       w_slot_free;
    logic       w_load;
    logic       w_last;
    logic       w_first;

    assign w_pos = '{row: r_row, col: POS_COL_W'(r_col)};

    stmn_oh_gen #(
        .STM_N     (STM_N),
        .PTR_VALUE (PTR_VALUE)
    ) u_oh_gen (
        .i_pos         (w_pos),
        .i_j0_idx      (r_j0_idx),
        .o_byte        (w_oh_byte),
        .o_is_overhead (w_is_oh)
    );

    assign w_run       = (r_state == ST_RUN);
    assign w_slot_free = !r_out_valid || out_ready;
    // Overhead never waits for upstream; payload columns need a valid byte.
    assign w_load      = w_run && w_slot_free && (w_is_oh || in_valid);
    assign w_last      = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_first     = (r_row == 4'd0) && (r_col == '0);

    assign in_ready = w_run && !w_is_oh && w_slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_row       <= 4'd0;
            r_col       <= '0;
            r_j0_idx    <= 4'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // enable only matters once the final byte of a frame goes out.
                    if (w_load && w_last && !enable) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase

            if (w_load) begin
                r_out_data  <= w_is_oh ? w_oh_byte : in_data;
                r_out_valid <= 1'b1;
                r_out_sof   <= w_first;
                if (w_last) begin
                    r_row       <= 4'd0;
                    r_col       <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_j0_idx    <= (r_j0_idx == LAST_J0) ? 4'd0 : r_j0_idx + 4'd1;
                end else if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 4'd1;
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_sof   <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign frame_cnt = r_frame_cnt;

endmodule
